// File: rtl/img_recon_if.sv
// img_recon_if: gradient-read / image-write bus of the gradient integrator.
// Signals:
//   start, seed          control pulse and pixel (0,0) value into the engine
//   grad_rd, grad_addr   gradient SRAM read strobe and word address
//   grad_di              gradient word {gx, gy}, valid the cycle after grad_rd
//   img_wr, img_addr,    image SRAM write strobe, pixel address and value
//   img_do
//   busy, done, err      run status, completion pulse, sticky saturation flag
// Modports: master = controller/memory side, slave = img_recon.
interface img_recon_if;
    logic        start;
    logic [7:0]  seed;
    logic        grad_rd;
    logic [15:0] grad_addr;
    logic [19:0] grad_di;
    logic        img_wr;
    logic [15:0] img_addr;
    logic [7:0]  img_do;
    logic        busy;
    logic        done;
    logic        err;
    modport master (
        output start, seed, grad_di,
        input  grad_rd, grad_addr, img_wr, img_addr, img_do, busy, done, err
    );
    modport slave (
        input  start, seed, grad_di,
        output grad_rd, grad_addr, img_wr, img_addr, img_do, busy, done, err
    );
endinterface

// File: rtl/img_recon.sv
// img_recon: rebuilds a 256x256 8-bit image by integrating stored gradient words.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    img_recon_if.slave: start/seed in, gradient read port, image write
//          port, busy/done/err status (all outputs registered)
// Row 0 is chained from the seed through gx; every later row adds gy to the
// pixel directly above, kept in a one-row buffer.
module img_recon #(
    parameter int W = 256
) (
    input logic         clk,
    input logic         reset,
    img_recon_if.slave  bus
);
    localparam logic [16:0] NPIX = 17'(W * W);

    typedef enum logic [2:0] {IDLE, SEED, ROW0, ROWS, DRAIN, DONE} state_t;

    state_t      state;
    logic [16:0] k;
    logic [7:0]  row_buf [0:W-1];
    logic [15:0] kd;
    logic [7:0]  x;
    logic [9:0]  g;
    logic [7:0]  base;
    logic signed [10:0] sum;
    logic [7:0]  pix;
    logic        sat;

    // k is the cycle number since start was accepted; the data on grad_di in
    // cycle k belongs to pixel k-1, which is written in cycle k+1.
    assign kd   = k[15:0] - 16'd1;
    assign x    = kd[7:0];
    assign g    = state == ROW0 ? bus.grad_di[19:10] : bus.grad_di[9:0];
    // Row 0 chains from the pixel just produced; later rows read the one above.
    assign base = state == ROW0 ? bus.img_do : row_buf[x];
    assign sum  = $signed({3'b000, base}) + $signed({g[9], g});
    assign sat  = sum[10] | (|sum[9:8]);
    assign pix  = sum[10] ? 8'h00 : (|sum[9:8] ? 8'hff : sum[7:0]);

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start)
            row_buf[0] <= bus.seed;
        else if (state == ROW0 || state == ROWS)
            row_buf[x] <= pix;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            k             <= '0;
            bus.grad_rd   <= 1'b0;
            bus.grad_addr <= '0;
            bus.img_wr    <= 1'b0;
            bus.img_addr  <= '0;
            bus.img_do    <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else if (state == IDLE) begin
            bus.done <= 1'b0;
            if (bus.start) begin
                state         <= SEED;
                k             <= 17'd1;
                bus.grad_rd   <= 1'b1;
                bus.grad_addr <= '0;
                bus.busy      <= 1'b1;
                bus.err       <= 1'b0;
                bus.img_do    <= bus.seed;
            end
        end else begin
            k           <= k + 17'd1;
            bus.grad_rd <= k < NPIX - 17'd1;
            // Row 0 is fetched once for gx, then all rows from 0 again for gy.
            if (k < NPIX - 17'd1)
                bus.grad_addr <= k < 17'(W - 1) ? k[15:0] : k[15:0] - 16'(W - 1);
            bus.img_wr <= k < NPIX + 17'd1;
            if (k < NPIX + 17'd1)
                bus.img_addr <= kd;
            if (state == ROW0 || state == ROWS) begin
                bus.img_do <= pix;
                bus.err    <= bus.err | sat;
            end
            case (state)
                SEED:  state <= ROW0;
                ROW0:  if (k == 17'(W)) state <= ROWS;
                ROWS:  if (k == NPIX) state <= DRAIN;
                DRAIN: begin
                    state    <= DONE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_img_recon.sv
// tb_img_recon: self-checking bench for img_recon.
// Models the gradient SRAM (registered read) and image SRAM, predicts every
// pixel from the integration rules, and checks each cycle of each run.
module tb_img_recon;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    img_recon_if bus();
    img_recon dut (.clk(clk), .reset(reset), .bus(bus.slave));

    logic [19:0] gmem [0:65535];
    logic [7:0]  imem [0:65535];
    logic [7:0]  orig [0:65535];
    bit          written [0:65535];
    int          exp_img [0:65535];
    int          first_sat;
    int          dup_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.grad_di <= '0;
            for (int i = 0; i < 65536; i++) written[i] <= 1'b0;
        end else begin
            if (bus.grad_rd) bus.grad_di <= gmem[bus.grad_addr];
            if (bus.img_wr) begin
                if (written[bus.img_addr]) dup_cnt <= dup_cnt + 1;
                written[bus.img_addr] <= 1'b1;
                imem[bus.img_addr]    <= bus.img_do;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [9:0] v);
        return int'($signed(v));
    endfunction

    // Expected image: row 0 integrates gx from the seed, later rows add gy
    // to the pixel above; every result is clamped to 0..255.
    task automatic build_model(input logic [7:0] s);
        int v;
        first_sat  = -1;
        exp_img[0] = int'(s);
        for (int i = 1; i < 65536; i++) begin
            v = i < 256 ? exp_img[i-1] + sx(gmem[i-1][19:10])
                        : exp_img[i-256] + sx(gmem[i-256][9:0]);
            if ((v < 0 || v > 255) && first_sat < 0) first_sat = i;
            exp_img[i] = v < 0 ? 0 : (v > 255 ? 255 : v);
        end
    endtask

    task automatic check_cycle(input int k);
        bit          erd, ewr;
        logic [15:0] ega;
        int          idx;
        erd = k <= 65535;
        ewr = k >= 2 && k <= 65537;
        ega = 16'(k <= 255 ? k - 1 : k - 256);
        idx = ewr ? k - 2 : 0;
        chk($sformatf("rd@%0d", k), {bus.grad_rd, erd ? bus.grad_addr : 16'h0},
            {erd, erd ? ega : 16'h0});
        chk($sformatf("wr@%0d", k), {bus.img_wr, ewr ? {bus.img_addr, bus.img_do} : 24'h0},
            {ewr, ewr ? {16'(idx), 8'(exp_img[idx])} : 24'h0});
        chk($sformatf("ctl@%0d", k), {bus.busy, bus.done, bus.err},
            {k <= 65537, k == 65538, first_sat >= 0 && k - 2 >= first_sat});
    endtask

    // Starts a run with seed s and checks n cycles; stray start pulses with a
    // different seed arrive in cycles 10 and 40000.
    task automatic run(input logic [7:0] s, input int n, input bit restart);
        @(negedge clk);
        bus.start = 1'b1;
        bus.seed  = s;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            bus.start = k == 10 || k == 40000 || (restart && k == n);
            bus.seed  = bus.start ? ~s : s;
            check_cycle(k);
            if (errors > 20) break;
        end
    endtask

    task automatic reset_check(input string tag);
        #2 reset = 1'b1;
        #1 chk(tag, {bus.grad_rd, bus.grad_addr, bus.img_wr, bus.img_addr, bus.img_do,
                     bus.busy, bus.done, bus.err}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "_idle"}, {bus.grad_rd, bus.img_wr, bus.busy}, 3'b000);
        end
    endtask

    initial begin
        int mism, wcnt, d;
        logic [9:0] gx, gy;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.seed  = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {bus.grad_rd, bus.grad_addr, bus.img_wr, bus.img_addr, bus.img_do,
                            bus.busy, bus.done, bus.err}, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Negative saturation at pixel (0,1), random gradients elsewhere.
        for (int i = 0; i < 65536; i++) gmem[i] = 20'($urandom);
        gmem[0][19:10] = 10'h3F6;
        build_model(8'd5);
        run(8'd5, 600, 1'b0);
        chk("neg_pix1", imem[1], 8'd0);
        chk("neg_err", bus.err, 1'b1);
        reset_check("mid_reset");

        // Ramp: pixel(y,x) = min(x+y, 255); first clamp at address 511.
        for (int i = 0; i < 65536; i++) gmem[i] = {10'd1, 10'd1};
        build_model(8'd0);
        run(8'd0, 700, 1'b0);
        chk("ramp_px300", imem[300], 8'd45);
        chk("ramp_px255", imem[255], 8'd255);
        chk("ramp_err", bus.err, 1'b1);
        reset_check("ramp_reset");

        // Round trip of a random image; the final gy is forced to saturate.
        for (int i = 0; i < 65536; i++) orig[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 65536; i++) begin
            gx = 10'($urandom);
            gy = 10'($urandom);
            if (i < 255) begin
                d  = int'(orig[i+1]) - int'(orig[i]);
                gx = 10'(d);
            end
            if (i < 65280) begin
                d  = int'(orig[i+256]) - int'(orig[i]);
                gy = 10'(d);
            end
            gmem[i] = {gx, gy};
        end
        gmem[65279][9:0] = 10'd300;
        build_model(orig[0]);
        run(orig[0], 65539, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_err", bus.err, 1'b0);
        chk("restart_busy", bus.busy, 1'b1);
        chk("restart_rd", {bus.grad_rd, bus.grad_addr}, {1'b1, 16'h0});
        mism = 0;
        wcnt = 0;
        for (int i = 0; i < 65536; i++) begin
            if (i < 65535 && imem[i] !== orig[i]) mism++;
            if (written[i]) wcnt++;
        end
        chk("roundtrip_mismatches", mism, 0);
        chk("roundtrip_last", imem[65535], 8'd255);
        chk("write_count", wcnt, 65536);
        chk("dup_writes", dup_cnt, 0);
        reset_check("final_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
